sms_trigger_counter: RTL

SMS_TRIGGER_COUNTER -- requirements
Module: sms_trigger_counter

---
 rtl/sms_pkg.sv | 13 +
 rtl/sms_trigger_counter_if.sv | 32 +++
 rtl/sms_edge_detect.sv | 23 ++
 rtl/sms_trigger_counter.sv | 64 ++++++
 4 files changed

// File: rtl/sms_pkg.sv
// Shared constants for the SMS trigger-card counter family: default sizing
// and the binary/decimal mode encoding used on the decimal_mode pin.
package sms_pkg;

  localparam int WIDTH_DEFAULT   = 4;
  localparam int DEC_MAX_DEFAULT = 9;

  typedef enum logic {
    MODE_BINARY  = 1'b0,
    MODE_DECIMAL = 1'b1
  } mode_e;

endpackage

// File: rtl/sms_trigger_counter_if.sv
// Signal bundle between a trigger counter card and whatever drives it.
interface sms_trigger_counter_if
  import sms_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  // Level-based bus with no valid/ready handshake: inputs are sampled on
  // every rising clk edge; ac_set counts on its sampled rising edge when
  // gate is high; q/q_n/terminal are levels; carry_pulse is high for exactly
  // one cycle after a wrap.
  logic             ac_set;
  logic             gate;
  logic             decimal_mode;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             carry_pulse;
  logic             terminal;

  modport master (
    output ac_set, gate, decimal_mode, load, load_value,
    input  q, q_n, carry_pulse, terminal
  );

  modport slave (
    input  ac_set, gate, decimal_mode, load, load_value,
    output q, q_n, carry_pulse, terminal
  );

endinterface

// File: rtl/sms_edge_detect.sv
// Gated rising-edge detector for a trigger input level; reusable per card.
module sms_edge_detect (
  input  logic clk,
  input  logic reset_left,
  input  logic i_level,
  input  logic i_gate,
  output logic o_event
);

  logic r_prev;

  // Held at 1 through reset so a level already high at release is not an edge.
  always_ff @(posedge clk or posedge reset_left) begin
    if (reset_left) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_event = i_level & ~r_prev & i_gate;

endmodule

// File: rtl/sms_trigger_counter.sv
// One trigger counter card: gated ac_set edges advance a binary or decimal
// count; wrap produces a one-cycle carry that can feed the next card.
module sms_trigger_counter
  import sms_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int DEC_MAX = DEC_MAX_DEFAULT
) (
  input logic                  clk,
  input logic                  reset_left,
  sms_trigger_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] BIN_WRAP = '1;
  localparam logic [WIDTH-1:0] DEC_WRAP = WIDTH'(DEC_MAX);
  // Narrow cards cannot hold a decade, so they ignore decimal_mode.
  localparam bit DEC_SUPPORTED = (WIDTH >= 4);

  logic             w_advance;
  logic             w_dec_en;
  logic [WIDTH-1:0] w_wrap;
  logic             w_wrap_hit;
  logic [WIDTH-1:0] r_q;
  logic             r_carry;

  sms_edge_detect u_edge (
    .clk        (clk),
    .reset_left (reset_left),
    .i_level    (bus.ac_set),
    .i_gate     (bus.gate),
    .o_event    (w_advance)
  );

  assign w_dec_en = DEC_SUPPORTED && (mode_e'(bus.decimal_mode) == MODE_DECIMAL);
  assign w_wrap   = w_dec_en ? DEC_WRAP : BIN_WRAP;
  // ">=" also catches an out-of-range value left by a load or mode change.
  assign w_wrap_hit = (r_q >= w_wrap);

  always_ff @(posedge clk or posedge reset_left) begin
    if (reset_left) begin
      r_q     <= '0;
      r_carry <= 1'b0;
    end else if (bus.load) begin
      r_q     <= bus.load_value;
      r_carry <= 1'b0;
    end else if (w_advance) begin
      if (w_wrap_hit) begin
        r_q     <= '0;
        r_carry <= 1'b1;
      end else begin
        r_q     <= r_q + 1'b1;
        r_carry <= 1'b0;
      end
    end else begin
      r_carry <= 1'b0;
    end
  end

  assign bus.q           = r_q;
  assign bus.q_n         = ~r_q;
  assign bus.carry_pulse = r_carry;
  assign bus.terminal    = (r_q == w_wrap);

endmodule
